// File: rtl/uid_word_capture.sv
// Captures the UID words read from the UID ROM, packs them MSB-first into one
// vector and compares the result against an expected UID.
module uid_word_capture #(
    parameter int DATA_W     = 16,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 5,
    parameter int NUM_WORDS  = 5,
    parameter int RD_LAT     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  address,
    input  logic [DATA_W-1:0]           q,
    input  logic [NUM_WORDS*DATA_W-1:0] exp_uid,
    output logic [NUM_WORDS*DATA_W-1:0] uid,
    output logic                        uid_valid,
    output logic                        match,
    output logic                        err,
    output logic                        busy
);

    localparam int          UID_W     = NUM_WORDS * DATA_W;
    localparam logic [2:0]  FIRST_A   = FIRST_ADDR[2:0];
    localparam logic [2:0]  LAST_A    = LAST_ADDR[2:0];
    localparam logic [2:0]  LAST_SLOT = 3'(LAST_ADDR - FIRST_ADDR);
    localparam logic [2:0]  LAT_LOAD  = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LAT,
        CAPTURE,
        CHECK,
        DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [2:0]             prev_addr;
    logic                   primed;
    logic [2:0]             cnt, cnt_nxt;
    logic [2:0]             slot, slot_nxt;
    logic [NUM_WORDS-1:0]   mask, mask_nxt;
    logic [UID_W-1:0]       uid_nxt;
    logic                   uid_valid_nxt, match_nxt, err_nxt, busy_nxt;

    logic                   addr_chg;
    logic                   restart;
    logic                   in_range;
    state_t                 start_state;

    // prev_addr is only trusted after one clock out of reset, so an address
    // already parked on a UID word at reset release is not taken as a change.
    assign addr_chg    = primed && (address != prev_addr);
    assign restart     = addr_chg && (address == '0);
    assign in_range    = (address >= FIRST_A) && (address <= LAST_A);
    // CAPTURE is the cycle in which the latency counter sits at zero.
    assign start_state = (LAT_LOAD == '0) ? CAPTURE : WAIT_LAT;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        slot_nxt      = slot;
        mask_nxt      = mask;
        uid_nxt       = uid;
        uid_valid_nxt = uid_valid;
        match_nxt     = match;
        err_nxt       = err;
        busy_nxt      = busy;

        if (restart) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            mask_nxt      = '0;
            uid_valid_nxt = 1'b0;
            match_nxt     = 1'b0;
            err_nxt       = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_chg && in_range) begin
                        cnt_nxt   = LAT_LOAD;
                        slot_nxt  = address - FIRST_A;
                        busy_nxt  = 1'b1;
                        state_nxt = start_state;
                    end
                end

                WAIT_LAT: begin
                    if (addr_chg) begin
                        err_nxt = 1'b1;
                        if (in_range) begin
                            cnt_nxt   = LAT_LOAD;
                            slot_nxt  = address - FIRST_A;
                            state_nxt = start_state;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state_nxt = CAPTURE;
                        end
                    end
                end

                CAPTURE: begin
                    if (addr_chg) begin
                        err_nxt = 1'b1;
                        if (in_range) begin
                            cnt_nxt   = LAT_LOAD;
                            slot_nxt  = address - FIRST_A;
                            state_nxt = start_state;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                            if (slot == 3'(i)) begin
                                uid_nxt[(NUM_WORDS-1-i)*DATA_W +: DATA_W] = q;
                                mask_nxt[i] = 1'b1;
                            end
                        end
                        state_nxt = (slot == LAST_SLOT) ? CHECK : IDLE;
                    end
                end

                CHECK: begin
                    uid_valid_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    match_nxt     = (uid == exp_uid) && (&mask);
                    if (!(&mask)) begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = DONE;
                end

                DONE: begin
                    state_nxt = DONE;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prev_addr <= '0;
            primed    <= 1'b0;
            cnt       <= '0;
            slot      <= '0;
            mask      <= '0;
            uid       <= '0;
            uid_valid <= 1'b0;
            match     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev_addr <= address;
            primed    <= 1'b1;
            cnt       <= cnt_nxt;
            slot      <= slot_nxt;
            mask      <= mask_nxt;
            uid       <= uid_nxt;
            uid_valid <= uid_valid_nxt;
            match     <= match_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uid_word_capture.sv
// Bench for uid_word_capture: two builds (read latency 2 and 1) driven from one
// address stream, each checked every cycle against a timestamp-based model.
module tb_uid_word_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  address;
    logic [15:0] q_a, q_b;
    logic [79:0] exp_uid;

    logic [79:0] uid_a, uid_b;
    logic        uid_valid_a, match_a, err_a, busy_a;
    logic        uid_valid_b, match_b, err_b, busy_b;

    always #5 clk = ~clk;

    uid_word_capture #(.DATA_W(16), .FIRST_ADDR(1), .LAST_ADDR(5), .NUM_WORDS(5), .RD_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .address(address), .q(q_a), .exp_uid(exp_uid),
        .uid(uid_a), .uid_valid(uid_valid_a), .match(match_a), .err(err_a), .busy(busy_a)
    );

    uid_word_capture #(.DATA_W(16), .FIRST_ADDR(1), .LAST_ADDR(5), .NUM_WORDS(5), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .address(address), .q(q_b), .exp_uid(exp_uid),
        .uid(uid_b), .uid_valid(uid_valid_b), .match(match_b), .err(err_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [79:0] uid;
        logic        valid, match, err, busy;
        logic [4:0]  mask;
        logic        done, chk, pend, primed;
        logic [2:0]  slot, prev;
        int          due;
    } mdl_t;

    mdl_t        ma, mb;
    int          total = 0;
    int          bad   = 0;
    int          n     = 0;
    bit          rand_junk = 1'b0;
    logic [15:0] rom [0:7];
    logic [2:0]  addr_h [0:8191];
    bit          chg_h  [0:8191];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pending word is tracked as (slot, cycle it is due) rather than a counter.
    function automatic mdl_t mstep(input mdl_t s, input int lat, input logic [2:0] a,
                                   input logic [15:0] qv, input logic [79:0] eu, input int cyc);
        mdl_t r;
        bit   chg, inr;
        int   sl;
        r   = s;
        chg = s.primed && (a != s.prev);
        inr = (a >= 3'd1) && (a <= 3'd5);
        r.prev   = a;
        r.primed = 1'b1;
        if (chg && a == 3'd0) begin
            r.valid = 0; r.match = 0; r.err = 0; r.mask = '0;
            r.pend = 0; r.busy = 0; r.done = 0; r.chk = 0;
        end else if (s.done) begin
            r.done = 1'b1;
        end else if (s.chk) begin
            r.valid = 1'b1;
            r.busy  = 1'b0;
            r.match = (s.uid == eu) && (s.mask == 5'h1f);
            if (s.mask != 5'h1f) r.err = 1'b1;
            r.done = 1'b1;
            r.chk  = 1'b0;
        end else if (s.pend) begin
            if (chg) begin
                r.err  = 1'b1;
                r.pend = 1'b0;
                if (inr) begin
                    r.pend = 1'b1; r.slot = a - 3'd1; r.due = cyc + lat;
                end
            end else if (cyc == s.due) begin
                sl = int'(s.slot);
                r.uid[(4-sl)*16 +: 16] = qv;
                r.mask[sl] = 1'b1;
                r.pend = 1'b0;
                if (sl == 4) r.chk = 1'b1;
            end
        end else if (chg && inr) begin
            r.pend = 1'b1; r.slot = a - 3'd1; r.due = cyc + lat; r.busy = 1'b1;
        end
        return r;
    endfunction

    task automatic compare_all();
        check("l2.uid",   uid_a,       ma.uid);
        check("l2.valid", uid_valid_a, ma.valid);
        check("l2.match", match_a,     ma.match);
        check("l2.err",   err_a,       ma.err);
        check("l2.busy",  busy_a,      ma.busy);
        check("l1.uid",   uid_b,       mb.uid);
        check("l1.valid", uid_valid_b, mb.valid);
        check("l1.match", match_b,     mb.match);
        check("l1.err",   err_b,       mb.err);
        check("l1.busy",  busy_b,      mb.busy);
    endtask

    task automatic expect_both(input string tag, input logic [79:0] u, input logic v,
                               input logic m, input logic e, input logic b);
        check({tag, ".l2.uid"},   uid_a,       u);
        check({tag, ".l2.valid"}, uid_valid_a, v);
        check({tag, ".l2.match"}, match_a,     m);
        check({tag, ".l2.err"},   err_a,       e);
        check({tag, ".l2.busy"},  busy_a,      b);
        check({tag, ".l1.uid"},   uid_b,       u);
        check({tag, ".l1.valid"}, uid_valid_b, v);
        check({tag, ".l1.match"}, match_b,     m);
        check({tag, ".l1.err"},   err_b,       e);
        check({tag, ".l1.busy"},  busy_b,      b);
    endtask

    // Drives one cycle; q models a ROM whose data is only present exactly
    // RD_LAT cycles after an address change and junk otherwise.
    task automatic drive_cycle(input logic [2:0] a, input bit rst_mid);
        logic [15:0] junk;
        if (n >= 8190) begin
            $display("FAIL cycle_budget got=%0d exp=<8190", n);
            $display("test done: total=%0d bad=%0d", total, bad + 1);
            $fatal(1, "cycle budget exceeded");
        end
        junk      = rand_junk ? 16'($urandom) : 16'hDEAD;
        address   = a;
        addr_h[n] = a;
        chg_h[n]  = (n > 0) ? (a != addr_h[n-1]) : 1'b0;
        q_b = junk;
        q_a = junk;
        if (n >= 1 && chg_h[n-1]) q_b = rom[addr_h[n-1]];
        if (n >= 2 && chg_h[n-2]) q_a = rom[addr_h[n-2]];
        if (rst_mid) begin
            #3 rst = 1'b0;
            #1 expect_both("async_rst", 80'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            ma = '0;
            mb = '0;
        end else begin
            ma = mstep(ma, 2, a, q_a, exp_uid, n);
            mb = mstep(mb, 1, a, q_b, exp_uid, n);
        end
        @(posedge clk);
        #1;
        compare_all();
        n++;
        if (rst_mid) rst = 1'b1;
    endtask

    task automatic tick(input logic [2:0] a);
        drive_cycle(a, 1'b0);
    endtask

    task automatic hold(input logic [2:0] a, input int cycles);
        for (int i = 0; i < cycles; i++) tick(a);
    endtask

    task automatic load_rom(input logic [79:0] packed_words);
        for (int w = 1; w <= 5; w++) rom[w] = packed_words[(5-w)*16 +: 16];
    endtask

    task automatic sweep3();
        for (int w = 1; w <= 5; w++) hold(3'(w), 3);
    endtask

    initial begin
        rst = 1'b0; address = '0; q_a = '0; q_b = '0; exp_uid = '0;
        ma = '0; mb = '0;
        rom[0] = 16'h0000; rom[6] = 16'h6666; rom[7] = 16'h7777;
        load_rom(80'h0);
        repeat (2) @(posedge clk);
        #1 expect_both("reset", 80'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        hold(3'd0, 2);

        // Nominal sweep; uid_valid must rise one cycle after the last capture.
        load_rom(80'h1111_2222_3333_4444_5555);
        exp_uid = 80'h1111_2222_3333_4444_5555;
        for (int w = 1; w <= 4; w++) hold(3'(w), 3);
        hold(3'd5, 3);
        check("nom.l2.valid_at_capture", uid_valid_a, 1'b0);
        tick(3'd5);
        check("nom.l2.valid_next", uid_valid_a, 1'b1);
        tick(3'd5);
        expect_both("nominal", 80'h1111_2222_3333_4444_5555, 1'b1, 1'b1, 1'b0, 1'b0);

        // Mismatch in the last word only.
        hold(3'd0, 2);
        exp_uid = 80'h1111_2222_3333_4444_5556;
        sweep3();
        hold(3'd5, 2);
        expect_both("mismatch", 80'h1111_2222_3333_4444_5555, 1'b1, 1'b0, 1'b0, 1'b0);

        // Early change off address 2: word 2 keeps its old contents.
        hold(3'd0, 2);
        exp_uid = 80'h1111_2222_3333_4444_5555;
        rom[2] = 16'h9999;
        hold(3'd1, 3);
        tick(3'd2);
        tick(3'd3);
        check("early.l2.err", err_a, 1'b1);
        check("early.l1.err", err_b, 1'b1);
        hold(3'd3, 2);
        hold(3'd4, 3);
        hold(3'd5, 5);
        expect_both("early", 80'h1111_2222_3333_4444_5555, 1'b1, 1'b0, 1'b1, 1'b0);

        // Restart from DONE, then a fresh sweep.
        tick(3'd0);
        expect_both("restart", 80'h1111_2222_3333_4444_5555, 1'b0, 1'b0, 1'b0, 1'b0);
        load_rom(80'hAAAA_BBBB_CCCC_DDDD_EEEE);
        exp_uid = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
        tick(3'd0);
        sweep3();
        hold(3'd5, 2);
        expect_both("resweep", 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while address 3 is waiting out its latency.
        hold(3'd0, 2);
        load_rom(80'h1234_5678_9ABC_DEF0_0F0F);
        hold(3'd1, 3);
        hold(3'd2, 3);
        tick(3'd3);
        drive_cycle(3'd3, 1'b1);
        hold(3'd3, 5);
        expect_both("post_rst", 80'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(3'd4, 3);
        hold(3'd5, 5);
        expect_both("post_rst_end", 80'h0000_0000_0000_DEF0_0F0F, 1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        rand_junk = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [79:0] words;
            int          mode;
            hold(3'd0, int'($urandom_range(1, 2)));
            words = {$urandom, $urandom, 16'($urandom)};
            load_rom(words);
            exp_uid = ($urandom_range(0, 1) == 1) ? words : (words ^ (80'h1 << $urandom_range(0, 79)));
            mode = int'($urandom_range(0, 3));
            for (int w = 1; w <= 5; w++) begin
                if (mode == 3) begin
                    hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
                end else begin
                    if (mode == 2 && $urandom_range(0, 3) == 0) tick(3'($urandom_range(6, 7)));
                    if (it % 7 == 3 && w == 3) drive_cycle(3'(w), 1'b1);
                    hold(3'(w), (mode == 0) ? 3 : int'($urandom_range(1, 4)));
                end
            end
            hold(3'd5, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uid_word_capture.md
Name: uid_word_capture

Overview:
- Sits directly downstream of the UID ROM read sequencer.
- Watches the 3-bit ROM address the sequencer drives and the 16-bit ROM read data q.
- Captures each UID word once the ROM read latency has elapsed, and packs the five words into an 80-bit UID.
- Compares the packed UID against an expected UID and reports valid, match and error status to the trainer's control logic.

Parameters:
- DATA_W, 16, width of one ROM word.
- FIRST_ADDR, 1, first address holding a UID word.
- LAST_ADDR, 5, last address holding a UID word.
- NUM_WORDS, 5, number of UID words; must equal LAST_ADDR-FIRST_ADDR+1.
- RD_LAT, 2, cycles from an address change until q is valid; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- address  input  3  ROM address driven by the read sequencer.
- q  input  DATA_W  ROM read data.
- exp_uid  input  NUM_WORDS*DATA_W  expected UID; must be stable while busy.
- uid  output  NUM_WORDS*DATA_W  packed captured UID.
- uid_valid  output  1  high while a completed capture result is held.
- match  output  1  uid equals exp_uid; meaningful only when uid_valid=1.
- err  output  1  sequence error detected; sticky until cleared.
- busy  output  1  capture in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - uid=0, uid_valid=0, match=0, err=0, busy=0.
  - slot mask=0, latency counter=0, prev_addr=0, state=IDLE.
- prev_addr registers address every cycle. An address change means address != prev_addr.
- Packing: the word from FIRST_ADDR occupies uid[79:64]; the word from LAST_ADDR occupies uid[15:0] (MSB-first). Slot index = address-FIRST_ADDR.
- States:
  - IDLE:
    - On an address change to a value in [FIRST_ADDR, LAST_ADDR]: load the counter with RD_LAT-1, latch the target slot, set busy=1, go to WAIT_LAT.
    - Changes to addresses outside that range are ignored.
  - WAIT_LAT:
    - Decrement the counter each cycle.
    - When the counter reaches 0 and there is no address change in that cycle, go to CAPTURE.
    - An address change before capture: the pending word is dropped and err=1. If the new address is in range, restart WAIT_LAT for it; otherwise return to IDLE.
  - CAPTURE (one cycle):
    - Write q into the latched slot and set its mask bit.
    - If the slot is LAST_ADDR, go to CHECK; otherwise go to IDLE with busy held at 1.
  - CHECK (one cycle):
    - match=(uid==exp_uid) AND (mask all ones); uid_valid=1; busy=0.
    - An incomplete mask sets err=1 and forces match=0.
    - Go to DONE.
  - DONE:
    - Hold uid, match, uid_valid and err. Ignore further address changes except the restart condition below.
- Capture timing: q is sampled exactly RD_LAT cycles after the cycle in which the address changed.
  - With the sequencer's 3-cycle address hold and RD_LAT=2, each word is captured in the last cycle of its hold.
- Restart:
  - Address becomes 0 while prev_addr != 0, in any state, and at the same edge:
  - Clear uid_valid, match, err and the mask (uid keeps its old value), and go to IDLE.
  - Restart takes priority over CAPTURE and CHECK in the same cycle.
- Recapturing the same slot overwrites it; the mask bit stays set and this is not an error.
- Reset asserted mid-capture returns everything to reset values immediately. There is no partial result.
- Latency from the final capture to uid_valid=1 is one cycle (the CHECK cycle).

Test Plan:
1. Nominal capture: reset, then drive address 0→1→…→5 with each address held 3 cycles. q = 16'h1111, 2222, 3333, 4444, 5555 (valid 2 cycles after each change). exp_uid = 80'h11112222333344445555.
   - Required: uid_valid rises exactly 1 cycle after the address-5 capture, match=1, err=0, busy=0.
2. Mismatch: same stimulus with exp_uid[15:0]=16'h5556.
   - Required: uid_valid=1, match=0, err=0, uid[15:0]=16'h5555.
3. Early address change: address 2 held only 1 cycle before changing to 3.
   - Required: word 2 not captured, err=1 sticky. After address 5: uid_valid=1, match=0, mask bit 1 clear.
4. Restart: after DONE, drive address to 0.
   - Required: next cycle uid_valid=0, match=0, err=0, busy=0. A second full sweep with q=16'hAAAA.. produces the new uid and match per exp_uid.
5. Asynchronous reset: assert rst=0 mid-cycle during WAIT_LAT for address 3.
   - Required: all outputs 0 before the next clock edge. After release with address held at 3: no capture until an address change.
6. Latency boundary: RD_LAT=1 build, nominal sweep.
   - Required: each word sampled 1 cycle after its change. q forced to 16'hDEAD only in the cycle after sampling must not appear in uid.
